// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction field positions and
// fixed encodings used by the fetch, decode and instruction memory blocks.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC     = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP      = 6'b111111;
  localparam int          DRAIN_CYCLES = 4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register for {instruction, pc+4, valid} with load enable and a
// squash input that forces a bubble; clear has priority over load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instru_d,
  input  logic [31:0] pc4_d,
  input  logic        valid_d,
  output logic [31:0] instru_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instru_q <= NOP_INSTR;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
    end else if (clr) begin
      instru_q <= NOP_INSTR;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
    end else if (en) begin
      instru_q <= instru_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF stage: program counter, next-PC selection, halt detection/drain FSM and
// the IF/ID register feeding the decode stage.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_BOOT   | one cycle after reset; boot-slot word ignored, pc -> 0
//   ST_RUN    | normal fetch; stall holds, flush redirects, halt -> drain
//   ST_DRAIN  | halt seen; bubbles issued while drain counter runs down
//   ST_HALTED | pipeline empty, halted asserted; only rst leaves
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR    = cpu_pkg::NOP_INSTR,
  parameter logic [5:0]  HALT_OP      = cpu_pkg::HALT_OP,
  parameter int          DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_addr,
  input  logic [31:0] instru_in,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instru,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  fetch_state_t  state_q, state_nxt;
  logic [31:0]   pc_q, pc_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          halted_q, halted_nxt;
  logic          ifid_en, ifid_clr;
  logic [31:0]   pc_plus4;
  logic [31:0]   redirect_pc;
  logic          halt_seen;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {redirect_addr[31:2], 2'b00};
  assign halt_seen   = (opcode_of(instru_in) == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pc_q     <= pc_nxt;
      cnt_q    <= cnt_nxt;
      halted_q <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    pc_nxt     = pc_q;
    cnt_nxt    = cnt_q;
    halted_nxt = halted_q;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        ifid_clr  = 1'b1;
        state_nxt = ST_RUN;
        pc_nxt    = flush ? redirect_pc : 32'd0;
        cnt_nxt   = '0;
      end
      ST_RUN: begin
        if (flush) begin
          pc_nxt   = redirect_pc;
          ifid_clr = 1'b1;
          cnt_nxt  = '0;
        end else if (!stall) begin
          if (halt_seen) begin
            // halt word itself is never forwarded; pc parks on it
            ifid_clr  = 1'b1;
            state_nxt = ST_DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end else begin
            pc_nxt  = pc_plus4;
            ifid_en = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        ifid_clr = 1'b1;
        if (flush) begin
          // an older branch resolved: the halt was on a wrong path
          pc_nxt    = redirect_pc;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (!stall) begin
          if (cnt_q == '0) begin
            state_nxt  = ST_HALTED;
            halted_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
      end
      ST_HALTED: begin
      end
      default: begin
        state_nxt = ST_BOOT;
        pc_nxt    = RESET_PC;
        ifid_clr  = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .en       (ifid_en),
    .clr      (ifid_clr),
    .instru_d (instru_in),
    .pc4_d    (pc_plus4),
    .valid_d  (1'b1),
    .instru_q (ifid_instru),
    .pc4_q    (ifid_pc4),
    .valid_q  (ifid_valid)
  );

  assign pc_out    = pc_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small combinational instruction memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] redirect_addr, instru_in;
  logic [31:0] pc_out, ifid_instru, ifid_pc4;
  logic        ifid_valid, halted;
  logic [1:0]  state_dbg;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // addresses above the table (including the -4 boot slot) read as halt
  assign instru_in = (pc_out[31:8] != 24'd0) ? 32'hFC00_0000 : mem[pc_out[7:2]];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_addr(redirect_addr), .instru_in(instru_in),
    .pc_out(pc_out), .ifid_instru(ifid_instru), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_addr = 32'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic run_to_halt();
    do_reset();
    repeat (5) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc got %h want fffffffc", pc_out); end
    n_checks++; if (ifid_instru !== 32'h0) begin n_fail++; $display("FAIL reset_instru got %h want 0", ifid_instru); end
    n_checks++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", ifid_pc4); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_fetch();
    step();
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL boot_pc got %h want 0", pc_out); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", ifid_valid); end
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL boot_state got %0d want 1", state_dbg); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL boot_halt_ignored got %b want 0", halted); end
    step();
    n_checks++; if (ifid_instru !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch0_instru got %h want 20080005", ifid_instru); end
    n_checks++; if (ifid_pc4 !== 32'h4) begin n_fail++; $display("FAIL fetch0_pc4 got %h want 4", ifid_pc4); end
    n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL fetch0_valid got %b want 1", ifid_valid); end
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL fetch0_pc got %h want 4", pc_out); end
    step();
    n_checks++; if (ifid_instru !== 32'h2009_0003) begin n_fail++; $display("FAIL fetch1_instru got %h want 20090003", ifid_instru); end
    n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL fetch1_pc got %h want 8", pc_out); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc cyc%0d got %h want 8", i, pc_out); end
      n_checks++; if (ifid_instru !== 32'h2009_0003) begin n_fail++; $display("FAIL stall_instru cyc%0d got %h want 20090003", i, ifid_instru); end
      n_checks++; if (ifid_pc4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc4 cyc%0d got %h want 8", i, ifid_pc4); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL release_pc got %h want c", pc_out); end
    n_checks++; if (ifid_instru !== 32'h0123_4567) begin n_fail++; $display("FAIL release_instru got %h want 01234567", ifid_instru); end
    n_checks++; if (ifid_pc4 !== 32'hC) begin n_fail++; $display("FAIL release_pc4 got %h want c", ifid_pc4); end
    step();
    n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL adv_pc got %h want 10", pc_out); end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; redirect_addr = 32'h0000_0023;
    step();
    flush = 1'b0; stall = 1'b0;
    n_checks++; if (pc_out !== 32'h20) begin n_fail++; $display("FAIL flush_pc got %h want 20", pc_out); end
    n_checks++; if (ifid_instru !== 32'h0) begin n_fail++; $display("FAIL flush_instru got %h want 0", ifid_instru); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", ifid_valid); end
    step();
    n_checks++; if (ifid_instru !== 32'h2000_0008) begin n_fail++; $display("FAIL postflush_instru got %h want 20000008", ifid_instru); end
    n_checks++; if (ifid_pc4 !== 32'h24) begin n_fail++; $display("FAIL postflush_pc4 got %h want 24", ifid_pc4); end
    n_checks++; if (pc_out !== 32'h24) begin n_fail++; $display("FAIL postflush_pc got %h want 24", pc_out); end
  endtask

  task automatic test_halt();
    int n;
    mem[3] = 32'hFC00_0000;
    run_to_halt();
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL halt_pc got %h want c", pc_out); end
    n_checks++; if (ifid_instru !== 32'h0) begin n_fail++; $display("FAIL halt_instru got %h want 0", ifid_instru); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b want 0", ifid_valid); end
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL halt_state got %0d want 2", state_dbg); end
    n = 0;
    while (!halted && n < 12) begin step(); n++; end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL halt_latency got %0d want 4", n); end
    n_checks++; if (state_dbg !== 2'd3) begin n_fail++; $display("FAIL halted_state got %0d want 3", state_dbg); end
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL halted_pc got %h want c", pc_out); end
    flush = 1'b1; redirect_addr = 32'h80;
    step();
    flush = 1'b0;
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL halted_flush_pc got %h want c", pc_out); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted_flush_halted got %b want 1", halted); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_halted_pc got %h want fffffffc", pc_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted_halted got %b want 0", halted); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_halted_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_halt_stall();
    int n;
    run_to_halt();
    stall = 1'b1;
    step();
    stall = 1'b0;
    n = 1;
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL drain_stall_state got %0d want 2", state_dbg); end
    while (!halted && n < 12) begin step(); n++; end
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL halt_stall_latency got %0d want 5", n); end
  endtask

  task automatic test_drain_flush();
    run_to_halt();
    repeat (2) step();
    flush = 1'b1; redirect_addr = 32'h40;
    step();
    flush = 1'b0;
    n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL dflush_pc got %h want 40", pc_out); end
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL dflush_state got %0d want 1", state_dbg); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL dflush_valid got %b want 0", ifid_valid); end
    step();
    n_checks++; if (ifid_instru !== 32'h2000_0010) begin n_fail++; $display("FAIL dflush_next_instru got %h want 20000010", ifid_instru); end
    n_checks++; if (ifid_pc4 !== 32'h44) begin n_fail++; $display("FAIL dflush_next_pc4 got %h want 44", ifid_pc4); end
    n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL dflush_next_valid got %b want 1", ifid_valid); end
    repeat (6) step();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL dflush_halted got %b want 0", halted); end
    n_checks++; if (pc_out !== 32'h5C) begin n_fail++; $display("FAIL dflush_run_pc got %h want 5c", pc_out); end
  endtask

  task automatic test_rst_drain();
    run_to_halt();
    repeat (2) step();
    rst = 1'b1; flush = 1'b1; redirect_addr = 32'h40;
    step();
    rst = 1'b0; flush = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_drain_pc got %h want fffffffc", pc_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_drain_halted got %b want 0", halted); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain_valid got %b want 0", ifid_valid); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_drain_state got %0d want 0", state_dbg); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0123_4567;
    mem[3] = 32'h2010_0001;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_addr = 32'd0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_halt();
    test_halt_stall();
    test_drain_flush();
    test_rst_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
